ext_bus_bridge: RTL and testbench

Parametrised Avalon-MM slave to external 4-phase parallel bus master. It is the next generation of the Nios external-bus bridge. Additions over the fixed 11-bit/16-bit version: configurable address and data width, an acknowledge timeout with error reporting, zero-byte-enable short-circuit, and a synchronised IRQ with edge detect. It sits between the Nios interconnect and off-chip or fabric peripherals.

---
 rtl/ext_bus_bridge_pkg.sv | 26 ++
 rtl/ext_bus_bridge_sync.sv | 23 ++
 rtl/ext_bus_bridge.sv | 177 +++++++++++++++++
 tb/tb_ext_bus_bridge.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ext_bus_bridge_pkg.sv
// Shared types and constants for the Avalon-MM to 4-phase external bus bridge.
// Contents: bridge FSM state type, error counter width, and the read-data
// fill pattern returned when an access times out.
package ext_bus_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ACK = 2'd1,
    S_RELEASE  = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  localparam int unsigned ERR_CNT_W  = 8;
  localparam int unsigned FILL_MAX_W = 512;

  // All-ones pattern of the requested width; callers cast down to their data width.
  function automatic logic [FILL_MAX_W-1:0] timeout_fill(input int unsigned width);
    logic [FILL_MAX_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < FILL_MAX_W; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/ext_bus_bridge_sync.sv
// N-stage reset-to-0 single-bit synchroniser.
// Ports: i_clk, i_rst_n (async active-low), i_d (asynchronous input),
//        o_q (synchronised output, last flop of the chain).
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift chain: stage 0 samples the async input.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/ext_bus_bridge.sv
// Avalon-MM slave to external 4-phase parallel bus master with ack timeout,
// zero-byte-enable short-circuit and synchronised IRQ edge detect.
// Ports: clk_clk/reset_reset_n; avs_* Avalon slave side (address, read, write,
//        byteenable, writedata, readdata, waitrequest); address/bus_enable/
//        byte_enable/rw/write_data/read_data/acknowledge external bus side;
//        irq in, irq_o/irq_rise out; timeout_err pulse and err_count status.
module ext_bus_bridge
  import ext_bus_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned BE_W       = DATA_W / 8
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [ADDR_W-1:0]    avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [BE_W-1:0]      avs_byteenable,
  input  logic [DATA_W-1:0]    avs_writedata,
  output logic [DATA_W-1:0]    avs_readdata,
  output logic                 avs_waitrequest,
  output logic [ADDR_W-1:0]    address,
  output logic                 bus_enable,
  output logic [BE_W-1:0]      byte_enable,
  output logic                 rw,
  output logic [DATA_W-1:0]    write_data,
  input  logic [DATA_W-1:0]    read_data,
  input  logic                 acknowledge,
  input  logic                 irq,
  output logic                 irq_o,
  output logic                 irq_rise,
  output logic                 timeout_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned       CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] RD_TIMEOUT = DATA_W'(timeout_fill(DATA_W));

  state_e               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]    r_address, w_address_nxt;
  logic [BE_W-1:0]      r_be, w_be_nxt;
  logic                 r_rw, w_rw_nxt;
  logic [DATA_W-1:0]    r_wdata, w_wdata_nxt;
  logic [DATA_W-1:0]    r_rdata, w_rdata_nxt;
  logic                 r_bus_en, w_bus_en_nxt;
  logic                 r_waitreq, w_waitreq_nxt;
  logic                 r_timeout_err, w_timeout_err_nxt;
  logic [ERR_CNT_W-1:0] r_err_cnt, w_err_cnt_inc;
  logic [ERR_CNT_W-1:0] w_err_cnt_nxt;
  logic                 w_irq_sync;
  logic                 r_irq_q;

  // State and registered outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_address     <= '0;
      r_be          <= '0;
      r_rw          <= 1'b1;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_bus_en      <= 1'b0;
      r_waitreq     <= 1'b1;
      r_timeout_err <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_address     <= w_address_nxt;
      r_be          <= w_be_nxt;
      r_rw          <= w_rw_nxt;
      r_wdata       <= w_wdata_nxt;
      r_rdata       <= w_rdata_nxt;
      r_bus_en      <= w_bus_en_nxt;
      r_waitreq     <= w_waitreq_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_err_cnt     <= w_err_cnt_nxt;
    end
  end

  assign w_err_cnt_inc = (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + ERR_CNT_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
    w_address_nxt     = r_address;
    w_be_nxt          = r_be;
    w_rw_nxt          = r_rw;
    w_wdata_nxt       = r_wdata;
    w_rdata_nxt       = r_rdata;
    w_bus_en_nxt      = r_bus_en;
    w_timeout_err_nxt = 1'b0;
    w_err_cnt_nxt     = r_err_cnt;

    case (r_state)
      S_IDLE: begin
        if (avs_read || avs_write) begin
          // Read has priority when both strobes are asserted.
          w_address_nxt = avs_address;
          w_be_nxt      = avs_byteenable;
          w_rw_nxt      = avs_read;
          w_wdata_nxt   = avs_read ? '0 : avs_writedata;
          if (|avs_byteenable) begin
            w_bus_en_nxt = 1'b1;
            w_state_nxt  = S_WAIT_ACK;
          end else begin
            w_rdata_nxt = '0;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_WAIT_ACK: begin
        if (acknowledge) begin
          if (r_rw) w_rdata_nxt = read_data;
          w_bus_en_nxt = 1'b0;
          w_state_nxt  = S_RELEASE;
        end else if (r_cnt == CNT_LAST) begin
          w_bus_en_nxt      = 1'b0;
          w_rdata_nxt       = RD_TIMEOUT;
          w_timeout_err_nxt = 1'b1;
          w_err_cnt_nxt     = w_err_cnt_inc;
          w_state_nxt       = S_DONE;
        end
      end
      S_RELEASE: begin
        if (!acknowledge) begin
          w_state_nxt = S_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout_err_nxt = 1'b1;
          w_err_cnt_nxt     = w_err_cnt_inc;
          w_state_nxt       = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Counter measures time spent in the current state only.
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
    w_waitreq_nxt = (w_state_nxt != S_DONE);
  end

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_irq_sync (
    .i_clk   (clk_clk),
    .i_rst_n (reset_reset_n),
    .i_d     (irq),
    .o_q     (w_irq_sync)
  );

  // Previous synchronised level for rising-edge detect.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_irq_q <= 1'b0;
    else                r_irq_q <= w_irq_sync;
  end

  assign avs_readdata    = r_rdata;
  assign avs_waitrequest = r_waitreq;
  assign address         = r_address;
  assign bus_enable      = r_bus_en;
  assign byte_enable     = r_be;
  assign rw              = r_rw;
  assign write_data      = r_wdata;
  assign timeout_err     = r_timeout_err;
  assign err_count       = r_err_cnt;
  assign irq_o           = w_irq_sync;
  assign irq_rise        = w_irq_sync & ~r_irq_q;

endmodule

// File: tb/tb_ext_bus_bridge.sv
// Self-checking bench for ext_bus_bridge: directed and randomized transactions
// against a cycle-count reference model, plus IRQ synchroniser and reset checks.
module tb_ext_bus_bridge;

  localparam int ADDR_W      = 11;
  localparam int DATA_W      = 16;
  localparam int BE_W        = DATA_W / 8;
  localparam int TIMEOUT     = 8;
  localparam int SYNC_STAGES = 2;

  logic              clk_clk = 1'b0;
  logic              reset_reset_n = 1'b0;
  logic [ADDR_W-1:0] avs_address = '0;
  logic              avs_read = 1'b0;
  logic              avs_write = 1'b0;
  logic [BE_W-1:0]   avs_byteenable = '0;
  logic [DATA_W-1:0] avs_writedata = '0;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_waitrequest;
  logic [ADDR_W-1:0] address;
  logic              bus_enable;
  logic [BE_W-1:0]   byte_enable;
  logic              rw;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data = '0;
  logic              acknowledge = 1'b0;
  logic              irq = 1'b0;
  logic              irq_o;
  logic              irq_rise;
  logic              timeout_err;
  logic [7:0]        err_count;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state carried across transactions.
  int          exp_err   = 0;
  logic [15:0] exp_rdata = '0;

  ext_bus_bridge #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT     (TIMEOUT),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk_clk         (clk_clk),
    .reset_reset_n   (reset_reset_n),
    .avs_address     (avs_address),
    .avs_read        (avs_read),
    .avs_write       (avs_write),
    .avs_byteenable  (avs_byteenable),
    .avs_writedata   (avs_writedata),
    .avs_readdata    (avs_readdata),
    .avs_waitrequest (avs_waitrequest),
    .address         (address),
    .bus_enable      (bus_enable),
    .byte_enable     (byte_enable),
    .rw              (rw),
    .write_data      (write_data),
    .read_data       (read_data),
    .acknowledge     (acknowledge),
    .irq             (irq),
    .irq_o           (irq_o),
    .irq_rise        (irq_rise),
    .timeout_err     (timeout_err),
    .err_count       (err_count)
  );

  always #5 clk_clk = ~clk_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=time_limit expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // One Avalon access served by a behavioural 4-phase device.
  // dly: bus_enable cycles seen before the device acks (<0 = never).
  // rel: cycles ack stays high after bus_enable drops (<0 = stuck).
  task automatic run_txn(input bit rd, input bit wr, input logic [10:0] a,
                         input logic [15:0] wd, input logic [1:0] be,
                         input logic [15:0] dev_rd, input int dly, input int rel);
    int L, be_hi, n_hi, n_lo;
    bit is_rd, to_err;
    is_rd  = rd;
    to_err = 1'b0;
    // Expected timeline: sample t is the t-th falling edge after the request.
    if (be == 2'b00) begin
      L = 1; be_hi = 0; exp_rdata = 16'h0000;
    end else if (dly < 0 || dly >= TIMEOUT) begin
      L = TIMEOUT + 1; be_hi = TIMEOUT; exp_rdata = 16'hFFFF;
      to_err = 1'b1; exp_err = sat_inc(exp_err);
    end else begin
      be_hi = dly + 1;
      if (is_rd) exp_rdata = dev_rd;
      if (rel < 0 || rel >= TIMEOUT) begin
        L = dly + 2 + TIMEOUT; to_err = 1'b1; exp_err = sat_inc(exp_err);
      end else begin
        L = dly + 3 + rel;
      end
    end

    @(negedge clk_clk);
    avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = wd;
    avs_byteenable = be; read_data = dev_rd; acknowledge = 1'b0;
    n_hi = 0; n_lo = 0;
    for (int t = 1; t <= L; t++) begin
      @(negedge clk_clk);
      check("waitrequest", 32'(avs_waitrequest), 32'(t != L));
      check("bus_enable",  32'(bus_enable),      32'(t <= be_hi));
      check("timeout_err", 32'(timeout_err),     32'((t == L) && to_err));
      if (t == L) begin
        check("readdata",    32'(avs_readdata), 32'(exp_rdata));
        check("err_count",   32'(err_count),    32'(exp_err));
        check("address",     32'(address),      32'(a));
        check("rw",          32'(rw),           32'(is_rd));
        check("byte_enable", 32'(byte_enable),  32'(be));
        check("write_data",  32'(write_data),   is_rd ? 32'h0 : 32'(wd));
      end
      if (bus_enable) n_hi++;
      if (acknowledge && !bus_enable) n_lo++;
      if (!acknowledge) acknowledge = bus_enable && (dly >= 0) && (n_hi > dly);
      else              acknowledge = (rel < 0) || (n_lo <= rel);
    end
    avs_read = 1'b0; avs_write = 1'b0; acknowledge = 1'b0;
    @(negedge clk_clk);
    check("idle_waitrequest", 32'(avs_waitrequest), 32'h1);
    check("idle_bus_enable",  32'(bus_enable),      32'h0);
  endtask

  initial begin
    logic hist[$];
    logic nv;
    int   sz;

    // Reset values.
    @(negedge clk_clk);
    check("rst_waitrequest", 32'(avs_waitrequest), 32'h1);
    check("rst_bus_enable",  32'(bus_enable),      32'h0);
    check("rst_rw",          32'(rw),              32'h1);
    check("rst_address",     32'(address),         32'h0);
    check("rst_readdata",    32'(avs_readdata),    32'h0);
    check("rst_err_count",   32'(err_count),       32'h0);
    check("rst_irq_o",       32'(irq_o),           32'h0);
    check("rst_timeout_err", 32'(timeout_err),     32'h0);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);

    // Directed cases.
    run_txn(1'b0, 1'b1, 11'h155, 16'hA5C3, 2'b11, 16'h0000, 0, 2);   // write, ack 3 cycles
    run_txn(1'b1, 1'b0, 11'h7FF, 16'h0000, 2'b11, 16'h1234, 5, 0);   // read, slow ack
    run_txn(1'b1, 1'b0, 11'h0A0, 16'h0000, 2'b01, 16'h5555, -1, 0);  // ack never comes
    run_txn(1'b1, 1'b0, 11'h321, 16'h0000, 2'b10, 16'hBEEF, 1, -1);  // stuck ack
    run_txn(1'b0, 1'b1, 11'h010, 16'h9999, 2'b11, 16'h0000, 0, 0);   // recovers normally
    run_txn(1'b0, 1'b1, 11'h222, 16'h7777, 2'b00, 16'h0000, 0, 0);   // zero byte enable
    run_txn(1'b1, 1'b1, 11'h3C3, 16'hFACE, 2'b11, 16'h0F0F, 0, 0);   // read wins
    run_txn(1'b1, 1'b0, 11'h004, 16'h0000, 2'b11, 16'hC0DE, TIMEOUT - 1, TIMEOUT - 1); // last-cycle acks

    // Randomized transactions.
    for (int i = 0; i < 40; i++) begin
      bit          r, w;
      logic [1:0]  be;
      r  = 1'($urandom_range(0, 1));
      w  = r ? 1'($urandom_range(0, 1)) : 1'b1;
      be = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      run_txn(r, w, 11'($urandom), 16'($urandom), be, 16'($urandom),
              $urandom_range(0, 9), $urandom_range(0, 9));
    end

    // IRQ synchroniser: output follows input SYNC_STAGES edges later.
    hist = {1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_clk);
      sz = hist.size();
      check("irq_o",    32'(irq_o),    32'(hist[sz - SYNC_STAGES]));
      check("irq_rise", 32'(irq_rise), 32'(hist[sz - SYNC_STAGES] & ~hist[sz - SYNC_STAGES - 1]));
      if (k < 5)       nv = 1'b1;
      else if (k < 9)  nv = 1'b0;
      else             nv = ($urandom_range(0, 2) == 0) ? ~irq : irq;
      irq = nv;
      hist.push_back(nv);
    end
    irq = 1'b0;

    // Error counter saturation.
    for (int i = 0; i < 300; i++)
      run_txn(1'b1, 1'b0, 11'($urandom), 16'h0, 2'b11, 16'h0, -1, 0);
    check("err_saturated", 32'(err_count), 32'd255);

    // Asynchronous reset in the middle of WAIT_ACK.
    @(negedge clk_clk);
    avs_read = 1'b1; avs_address = 11'h155; avs_byteenable = 2'b11; acknowledge = 1'b0;
    @(negedge clk_clk);
    check("pre_rst_bus_enable", 32'(bus_enable), 32'h1);
    #2 reset_reset_n = 1'b0;
    #1;
    check("async_rst_bus_enable",  32'(bus_enable),      32'h0);
    check("async_rst_waitrequest", 32'(avs_waitrequest), 32'h1);
    check("async_rst_err_count",   32'(err_count),       32'h0);
    check("async_rst_rw",          32'(rw),              32'h1);
    avs_read = 1'b0;
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    exp_err = 0; exp_rdata = 16'h0;
    run_txn(1'b1, 1'b0, 11'h055, 16'h0, 2'b11, 16'h4321, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
